// File: rtl/generation_sequencer_if.sv
// rtl/generation_sequencer_if.sv - cell RAM bus between the generation sequencer and the double-buffered cell RAM
// Purpose: groups the front-bank read port, back-bank write port and bank select.
// Signals:
//   rd_addr  AW  front-bank read address (row*COLS+col)
//   rd_data  1   front-bank cell value, one cycle after rd_addr
//   wr_en    1   back-bank write strobe
//   wr_addr  AW  back-bank write address
//   wr_data  1   next cell state
//   bank_sel 1   front (displayed/read) bank; writes go to ~bank_sel
// Modports: master = sequencer side, slave = RAM side.
interface generation_sequencer_if #(
  parameter int AW = 6
);
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          bank_sel;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    output bank_sel,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  bank_sel,
    output rd_data
  );
endinterface

// File: rtl/generation_sequencer.sv
// rtl/generation_sequencer.sv - steps a toroidal Life grid one generation at a time
// Purpose: in RUN starts a generation every TICK_DIV cycles, in PAUSE one per step
//   pulse. Each cell reads its 3x3 wrapped neighbourhood from the front bank, writes
//   its next state to the back bank; after the last cell the banks swap.
// Ports:
//   i_clka        clock, all logic on posedge
//   i_stop        synchronous active-high reset
//   i_game_state  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE
//   i_step        single-generation request, honoured only in PAUSE
//   ram           cell RAM bus (master side)
//   o_busy        high while a generation is in progress
//   o_gen_done    one-cycle pulse on the swap cycle
//   o_gen_count   completed generations, wraps
module generation_sequencer #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int AW       = 6,
  parameter int TICK_DIV = 1000000,
  parameter int TW       = 20
) (
  input  logic                  i_clka,
  input  logic                  i_stop,
  input  logic [1:0]            i_game_state,
  input  logic                  i_step,
  generation_sequencer_if.master ram,
  output logic                  o_busy,
  output logic                  o_gen_done,
  output logic [15:0]           o_gen_count
);

  localparam logic [1:0] GS_RUN   = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_SWAP  = 3'd4;

  localparam logic [AW-1:0] LAST_CELL = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] ROW_LAST  = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_LAST  = AW'(COLS - 1);
  localparam logic [AW-1:0] COLS_W    = AW'(COLS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [AW-1:0] r_cell;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  // Neighbour offset counters: 0,1,2 mean -1,0,+1; row-major walk gives idx = dr*3+dc.
  logic [1:0]    r_dr;
  logic [1:0]    r_dc;
  logic [3:0]    r_sum;
  logic          r_centre;
  // Describes the read issued last cycle, whose data is on rd_data this cycle.
  logic          r_cap_vld;
  logic          r_cap_centre;
  logic [AW-1:0] r_rd_addr_hold;
  logic          r_bank_sel;
  logic [15:0]   r_gen_count;

  logic          w_keep;
  logic          w_tick;
  logic          w_start;
  logic [AW-1:0] w_nrow;
  logic [AW-1:0] w_ncol;
  logic [AW-1:0] w_nbr_addr;
  logic          w_write;

  // Only RUN and PAUSE let a generation continue; IDLE/PROGRAM abort it.
  assign w_keep  = i_game_state[1];
  assign w_tick  = (i_game_state == GS_RUN) && (r_tick_cnt == TICK_LAST);
  assign w_start = w_tick || ((i_game_state == GS_PAUSE) && i_step);

  always_comb begin
    w_nrow = r_row;
    if (r_dr == 2'd0) begin
      w_nrow = (r_row == '0) ? ROW_LAST : r_row - 1'b1;
    end else if (r_dr == 2'd2) begin
      w_nrow = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    end
  end

  always_comb begin
    w_ncol = r_col;
    if (r_dc == 2'd0) begin
      w_ncol = (r_col == '0) ? COL_LAST : r_col - 1'b1;
    end else if (r_dc == 2'd2) begin
      w_ncol = (r_col == COL_LAST) ? '0 : r_col + 1'b1;
    end
  end

  assign w_nbr_addr = w_nrow * COLS_W + w_ncol;

  // Writes are suppressed in the very cycle an abort is requested.
  assign w_write = (r_state == S_WRITE) && w_keep;

  assign ram.rd_addr  = (r_state == S_FETCH) ? w_nbr_addr : r_rd_addr_hold;
  assign ram.wr_en    = w_write;
  assign ram.wr_addr  = r_cell;
  assign ram.wr_data  = w_write && ((r_sum == 4'd3) || (r_centre && (r_sum == 4'd2)));
  assign ram.bank_sel = r_bank_sel;

  assign o_busy      = (r_state != S_IDLE);
  assign o_gen_done  = (r_state == S_SWAP) && w_keep;
  assign o_gen_count = r_gen_count;

  always_ff @(posedge i_clka) begin
    if (i_stop || (i_game_state != GS_RUN) || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clka) begin
    if (i_stop) begin
      r_state        <= S_IDLE;
      r_cell         <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_dr           <= '0;
      r_dc           <= '0;
      r_sum          <= '0;
      r_centre       <= 1'b0;
      r_cap_vld      <= 1'b0;
      r_cap_centre   <= 1'b0;
      r_rd_addr_hold <= '0;
      r_bank_sel     <= 1'b0;
      r_gen_count    <= '0;
    end else begin
      // Gated by w_keep so a stale capture cannot land on a sum cleared by a restart.
      r_cap_vld    <= (r_state == S_FETCH) && w_keep;
      r_cap_centre <= (r_dr == 2'd1) && (r_dc == 2'd1);

      if (r_cap_vld) begin
        if (r_cap_centre) begin
          r_centre <= ram.rd_data;
        end else begin
          r_sum <= r_sum + {3'b000, ram.rd_data};
        end
      end

      if ((r_state != S_IDLE) && !w_keep) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state <= S_FETCH;
              r_cell  <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_dr    <= '0;
              r_dc    <= '0;
              r_sum   <= '0;
            end
          end
          S_FETCH: begin
            r_rd_addr_hold <= w_nbr_addr;
            if (r_dc == 2'd2) begin
              r_dc <= '0;
              if (r_dr == 2'd2) begin
                r_dr    <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_dr <= r_dr + 1'b1;
              end
            end else begin
              r_dc <= r_dc + 1'b1;
            end
          end
          S_DRAIN: begin
            r_state <= S_WRITE;
          end
          S_WRITE: begin
            r_sum <= '0;
            r_dr  <= '0;
            r_dc  <= '0;
            if (r_cell == LAST_CELL) begin
              r_state <= S_SWAP;
            end else begin
              r_cell  <= r_cell + 1'b1;
              r_state <= S_FETCH;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
          S_SWAP: begin
            r_bank_sel  <= ~r_bank_sel;
            r_gen_count <= r_gen_count + 16'd1;
            r_state     <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
